// File: rtl/readout_pkg.sv
// Shared types and word-format constants for the region readout scheduler.
package readout_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPick,
    StAddr,
    StWait,
    StSend,
    StDone
  } stateT;

  localparam int REGION_W = 3;
  localparam int OSC_W    = 5;
  localparam int CNT_W    = 24;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

endpackage

// File: rtl/rr_region_picker.sv
// Combinational first-set-bit search over NumRegion request bits, starting at ptr and wrapping.
module rr_region_picker
  import readout_pkg::*;
#(
  parameter int NumRegion = 4
) (
  input  logic [NumRegion-1:0] reqVec,
  input  logic [REGION_W-1:0]  ptr,
  output logic [REGION_W-1:0]  idx,
  output logic                 anySet
);

  localparam int SumW = REGION_W + 1;

  logic [2*NumRegion-1:0] dbl;
  logic [NumRegion-1:0]   rot;
  logic [SumW-1:0]        sum;

  always_comb begin
    dbl    = {reqVec, reqVec};
    // rot[k] is the request bit of region (ptr+k) mod NumRegion
    rot    = NumRegion'(dbl >> ptr);
    idx    = '0;
    anySet = 1'b0;
    sum    = '0;
    // Descending scan so the smallest offset from ptr wins
    for (int k = NumRegion - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + SumW'(k);
        if (sum >= SumW'(NumRegion)) sum = sum - SumW'(NumRegion);
        idx    = sum[REGION_W-1:0];
        anySet = 1'b1;
      end
    end
  end

endmodule

// File: rtl/region_readout_scheduler.sv
// Scans per-region oscillator count RAMs and streams one word per oscillator (valid/ready).
// Define READOUT_FRAME_HDR_EN to prefix each scan with a {8'hA5, frame} header word.
module region_readout_scheduler
  import readout_pkg::*;
#(
  parameter int NumRegion = 4,
  parameter int NumOsc    = 10,
  parameter int RdLat     = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       Start_i,
  input  logic [NumRegion-1:0]       ReqMask_i,
  output logic [OSC_W-1:0]           Addr_o,
  input  logic [NumRegion*CNT_W-1:0] Data_i,
  output logic [31:0]                Dout_o,
  output logic                       Valid_o,
  input  logic                       Ready_i,
  output logic                       Last_o,
  output logic                       Busy_o,
  output logic                       Done_o
);

  // Stream handshake: a word transfers on a rising edge where Valid_o && Ready_i;
  // while Valid_o is high and Ready_i low, Dout_o and Last_o do not change.

  localparam logic [OSC_W-1:0]    LastOsc = OSC_W'(NumOsc - 1);
  localparam logic [REGION_W-1:0] LastReg = REGION_W'(NumRegion - 1);

  stateT                 state;
  logic [NumRegion-1:0]  pend;
  logic [REGION_W-1:0]   rrPtr;
  logic [REGION_W-1:0]   selReg;
  logic [OSC_W-1:0]      osc;
  logic [1:0]            waitCnt;
`ifdef READOUT_FRAME_HDR_EN
  logic [CNT_W-1:0]      frame;
`endif

  logic [REGION_W-1:0]   pickIdx;
  logic                  pickAny;
  logic [NumRegion-1:0]  pickMask;
  logic [CNT_W-1:0]      capData;

  rr_region_picker #(
    .NumRegion(NumRegion)
  ) uPicker (
    .reqVec(pend),
    .ptr   (rrPtr),
    .idx   (pickIdx),
    .anySet(pickAny)
  );

  always_comb begin
    pickMask = '0;
    capData  = '0;
    for (int r = 0; r < NumRegion; r++) begin
      pickMask[r] = (pickIdx == REGION_W'(r));
      if (selReg == REGION_W'(r)) capData = Data_i[r*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= StIdle;
      pend    <= '0;
      rrPtr   <= '0;
      selReg  <= '0;
      osc     <= '0;
      waitCnt <= '0;
      Addr_o  <= '0;
      Dout_o  <= '0;
      Valid_o <= 1'b0;
      Last_o  <= 1'b0;
      Busy_o  <= 1'b0;
      Done_o  <= 1'b0;
`ifdef READOUT_FRAME_HDR_EN
      frame   <= '0;
`endif
    end else begin
      Done_o <= 1'b0;
      case (state)
        StIdle: begin
          if (Start_i) begin
            pend   <= ReqMask_i;
            Busy_o <= 1'b1;
`ifdef READOUT_FRAME_HDR_EN
            Dout_o  <= {HDR_MAGIC, frame};
            Valid_o <= 1'b1;
            Last_o  <= (ReqMask_i == '0);
            state   <= StHdr;
`else
            state   <= StPick;
`endif
          end
        end
`ifdef READOUT_FRAME_HDR_EN
        StHdr: begin
          if (Ready_i) begin
            Valid_o <= 1'b0;
            Last_o  <= 1'b0;
            state   <= StPick;
          end
        end
`endif
        StPick: begin
          if (pickAny) begin
            selReg <= pickIdx;
            pend   <= pend & ~pickMask;
            osc    <= '0;
            Addr_o <= '0;
            state  <= StAddr;
          end else begin
            Busy_o <= 1'b0;
            Done_o <= 1'b1;
            state  <= StDone;
          end
        end
        StAddr: begin
          waitCnt <= 2'(RdLat - 1);
          state   <= StWait;
        end
        StWait: begin
          if (waitCnt == '0) begin
            Dout_o  <= {selReg, osc, capData};
            Valid_o <= 1'b1;
            // pend already excludes the current region, so empty means this is the final region
            Last_o  <= (osc == LastOsc) && (pend == '0);
            state   <= StSend;
          end else begin
            waitCnt <= waitCnt - 2'd1;
          end
        end
        StSend: begin
          if (Ready_i) begin
            Valid_o <= 1'b0;
            Last_o  <= 1'b0;
            if (osc != LastOsc) begin
              osc    <= osc + 5'd1;
              Addr_o <= osc + 5'd1;
              state  <= StAddr;
            end else if (pend != '0) begin
              state  <= StPick;
            end else begin
              Busy_o <= 1'b0;
              Done_o <= 1'b1;
              state  <= StDone;
            end
          end
        end
        StDone: begin
          rrPtr <= (rrPtr == LastReg) ? '0 : rrPtr + 3'd1;
`ifdef READOUT_FRAME_HDR_EN
          frame <= frame + 24'd1;
`endif
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_region_readout_scheduler.sv
// Directed bench for region_readout_scheduler: table of scans plus hand-written corner sequences.
module tb_region_readout_scheduler;

  localparam int NR = 4;
  localparam int NO = 10;

  logic             clk;
  logic             rstn;
  logic             Start_i;
  logic [NR-1:0]    ReqMask_i;
  logic [4:0]       Addr_o;
  logic [NR*24-1:0] Data_i;
  logic [31:0]      Dout_o;
  logic             Valid_o;
  logic             Ready_i;
  logic             Last_o;
  logic             Busy_o;
  logic             Done_o;

  region_readout_scheduler #(
    .NumRegion(NR),
    .NumOsc   (NO),
    .RdLat    (1)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .Start_i  (Start_i),
    .ReqMask_i(ReqMask_i),
    .Addr_o   (Addr_o),
    .Data_i   (Data_i),
    .Dout_o   (Dout_o),
    .Valid_o  (Valid_o),
    .Ready_i  (Ready_i),
    .Last_o   (Last_o),
    .Busy_o   (Busy_o),
    .Done_o   (Done_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: one registered read stage, count = region*100 + osc
  logic [23:0] ram_q [NR];
  always @(posedge clk) begin
    for (int r = 0; r < NR; r++) ram_q[r] <= 24'(r * 100) + {19'b0, Addr_o};
  end
  always_comb begin
    Data_i = '0;
    for (int r = 0; r < NR; r++) Data_i[r*24 +: 24] = ram_q[r];
  end

  // ---------------- scoreboard ----------------
  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q[$];
  int          model_ptr;
  logic [23:0] frame_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic build_expected(input logic [NR-1:0] mask);
    int r;
    exp_q.delete();
`ifdef READOUT_FRAME_HDR_EN
    exp_q.push_back({8'hA5, frame_model});
`endif
    for (int k = 0; k < NR; k++) begin
      r = (model_ptr + k) % NR;
      if (mask[r]) begin
        for (int o = 0; o < NO; o++) exp_q.push_back({3'(r), 5'(o), 24'(r * 100 + o)});
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_scan(input logic [NR-1:0] mask, input int stall_word, input bit mid_start,
                          output int n_words, output int first_region, output int n_done);
    int          stall_left;
    int          cycles;
    int          extra;
    int          skip;
    bit          held;
    bit          done;
    logic [31:0] held_dout;
    logic        held_last;
    logic [31:0] expw;
    stall_left = 7;
    cycles = 0;
    extra = 0;
    held = 1'b0;
    done = 1'b0;
    held_dout = '0;
    held_last = 1'b0;
    n_words = 0;
    first_region = -1;
    n_done = 0;
`ifdef READOUT_FRAME_HDR_EN
    skip = 1;
`else
    skip = 0;
`endif
    build_expected(mask);
    @(negedge clk);
    Start_i = 1'b1;
    ReqMask_i = mask;
    Ready_i = 1'b1;
    @(negedge clk);
    Start_i = 1'b0;
    while (!done && cycles < 2000) begin
      if (Valid_o && n_words == stall_word && stall_left > 0) begin
        Ready_i = 1'b0;
        stall_left--;
      end else begin
        Ready_i = 1'b1;
      end
      Start_i = (mid_start && Valid_o && n_words == 3);
      if (held) begin
        check("stall_valid", 32'(Valid_o), 32'd1);
        check("stall_dout", Dout_o, held_dout);
        check("stall_last", 32'(Last_o), 32'(held_last));
        held = 1'b0;
      end
      if (Valid_o && !Ready_i) begin
        held = 1'b1;
        held_dout = Dout_o;
        held_last = Last_o;
      end
      if (Valid_o && Ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_word: actual=%h required=none", Dout_o);
        end else begin
          expw = exp_q.pop_front();
          check("word", Dout_o, expw);
          check("last", 32'(Last_o), 32'(exp_q.size() == 0));
        end
        if (n_words == 0) check("busy_during_scan", 32'(Busy_o), 32'd1);
        if (n_words == skip) first_region = int'(Dout_o[31:29]);
        n_words++;
      end
      if (Done_o) begin
        n_done++;
        check("busy_at_done", 32'(Busy_o), 32'd0);
        done = 1'b1;
      end else begin
        cycles++;
        @(negedge clk);
      end
    end
    Start_i = 1'b0;
    Ready_i = 1'b1;
    if (!done) check("scan_timeout", 32'(done), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (Done_o) n_done++;
      if (Valid_o) extra++;
    end
    check("quiet_after_done", 32'(extra), 32'd0);
    check("missing_words", 32'(exp_q.size()), 32'd0);
    model_ptr = (model_ptr + 1) % NR;
    frame_model = frame_model + 24'd1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [NR-1:0] mask;
    int            stall_word;
    bit            mid_start;
    int            exp_words;
    int            exp_first;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          n_words;
    int          first_region;
    int          n_done;
    int          hdr_words;
    int          got;
    bit          hit;
    logic [31:0] expw;

    vecs[0] = '{4'b1111, -1, 1'b0, 40, 0};
    vecs[1] = '{4'b1111,  5, 1'b0, 40, 1};
    vecs[2] = '{4'b1111, -1, 1'b1, 40, 2};
    vecs[3] = '{4'b0001, -1, 1'b0, 10, 0};
    vecs[4] = '{4'b0000, -1, 1'b0,  0, -1};
    vecs[5] = '{4'b1000, -1, 1'b0, 10, 3};
    vecs[6] = '{4'b1010, -1, 1'b0, 20, 3};

    n_cmp = 0;
    n_err = 0;
    model_ptr = 0;
    frame_model = '0;
`ifdef READOUT_FRAME_HDR_EN
    hdr_words = 1;
`else
    hdr_words = 0;
`endif

    // reset state
    rstn = 1'b0;
    Start_i = 1'b0;
    ReqMask_i = '0;
    Ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(Valid_o), 32'd0);
    check("rst_busy", 32'(Busy_o), 32'd0);
    check("rst_done", 32'(Done_o), 32'd0);
    check("rst_last", 32'(Last_o), 32'd0);
    check("rst_dout", Dout_o, 32'd0);
    check("rst_addr", 32'(Addr_o), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // table-driven scans
    for (int v = 0; v < 7; v++) begin
      run_scan(vecs[v].mask, vecs[v].stall_word, vecs[v].mid_start, n_words, first_region, n_done);
      check($sformatf("v%0d_words", v), 32'(n_words), 32'(vecs[v].exp_words + hdr_words));
      check($sformatf("v%0d_first_region", v), 32'(first_region), 32'(vecs[v].exp_first));
      check($sformatf("v%0d_done_count", v), 32'(n_done), 32'd1);
    end

`ifndef READOUT_FRAME_HDR_EN
    // empty mask: Done_o two cycles after Start_i, no words
    @(negedge clk);
    Start_i = 1'b1;
    ReqMask_i = '0;
    @(negedge clk);
    Start_i = 1'b0;
    check("empty_done_early", 32'(Done_o), 32'd0);
    check("empty_busy", 32'(Busy_o), 32'd1);
    @(negedge clk);
    check("empty_done", 32'(Done_o), 32'd1);
    check("empty_busy_at_done", 32'(Busy_o), 32'd0);
    check("empty_valid", 32'(Valid_o), 32'd0);
    @(negedge clk);
    check("empty_done_one_cycle", 32'(Done_o), 32'd0);
    model_ptr = (model_ptr + 1) % NR;
    frame_model = frame_model + 24'd1;
    repeat (2) @(negedge clk);
`endif

    // reset while word 12 is waiting in SEND
    build_expected(4'b1111);
    @(negedge clk);
    Start_i = 1'b1;
    ReqMask_i = 4'b1111;
    Ready_i = 1'b1;
    @(negedge clk);
    Start_i = 1'b0;
    got = 0;
    hit = 1'b0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      if (Valid_o && got == 12) begin
        Ready_i = 1'b0;
        rstn = 1'b0;
        hit = 1'b1;
      end else begin
        Ready_i = 1'b1;
        if (Valid_o) begin
          if (exp_q.size() != 0) begin
            expw = exp_q.pop_front();
            check("pre_rst_word", Dout_o, expw);
          end
          got++;
        end
        @(negedge clk);
      end
    end
    check("pre_rst_reached", 32'(hit), 32'd1);
    @(negedge clk);
    check("mid_rst_valid", 32'(Valid_o), 32'd0);
    check("mid_rst_busy", 32'(Busy_o), 32'd0);
    check("mid_rst_done", 32'(Done_o), 32'd0);
    rstn = 1'b1;
    Ready_i = 1'b1;
    @(negedge clk);
    check("post_rst_no_done", 32'(Done_o), 32'd0);
    model_ptr = 0;
    frame_model = '0;
    run_scan(4'b1111, -1, 1'b0, n_words, first_region, n_done);
    check("post_rst_words", 32'(n_words), 32'(40 + hdr_words));
    check("post_rst_first_region", 32'(first_region), 32'd0);
    check("post_rst_done_count", 32'(n_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
